// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and operand-extension helper for the Booth multiplier
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_e;
  // Returns the extension bit placed above an operand's MSB: copy of the sign, or 0 when unsigned
  function automatic logic booth_ext(input logic value, input logic unsigned_flag);
    return value & ~unsigned_flag;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (conditional add/sub, then arithmetic shift right)
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+2:0] p,
  input  logic [2*WIDTH+2:0] a,
  input  logic [2*WIDTH+2:0] s,
  output logic [2*WIDTH+2:0] p_next
);
  logic [2*WIDTH+2:0] sum;
  always_comb begin
    sum = p[1:0] == 2'b01 ? p + a : p[1:0] == 2'b10 ? p + s : p;
    p_next = {sum[2*WIDTH+2], sum[2*WIDTH+2:1]};
  end
endmodule

// File: rtl/booth_muldiv_seq.sv
// booth_muldiv_seq: iterative Booth multiply / multiply-accumulate owning the Hi/Lo pair
module booth_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] MultA,
  input  logic [WIDTH-1:0] MultB,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int PW = 2*WIDTH + 3;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    a, s, p, p_next;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]   a_ext, b_ext;
  assign a_ext = {booth_ext(MultA[WIDTH-1], Op[0]), MultA};
  assign b_ext = {booth_ext(MultB[WIDTH-1], Op[0]), MultB};
  booth_step #(.WIDTH(WIDTH)) u_step (.p(p), .a(a), .s(s), .p_next(p_next));
  // mthi/mtlo are applied first so the WRITE-state result overrides a coincident write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      a     <= '0;
      s     <= '0;
      p     <= '0;
      acc   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      Done <= 1'b0;
      if (HiWe) Hi <= WrData;
      if (LoWe) Lo <= WrData;
      unique case (state)
        S_IDLE: if (Start) begin
          a     <= {a_ext, (WIDTH+2)'(0)};
          s     <= -{a_ext, (WIDTH+2)'(0)};
          p     <= {(WIDTH+1)'(0), b_ext, 1'b0};
          acc   <= Op[1] ? {Hi, Lo} : '0;
          cnt   <= '0;
          Busy  <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH)) state <= S_WRITE;
        end
        S_WRITE: begin
          {Hi, Lo} <= p[2*WIDTH:1] + acc;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_muldiv_seq.sv
// tb_booth_muldiv_seq: vector table, hand sequences and random checks against an arithmetic model
module tb_booth_muldiv_seq;
  logic        Clk = 0, Reset = 1, Start = 0, HiWe = 0, LoWe = 0;
  logic [1:0]  Op = 0;
  logic [31:0] MultA = 0, MultB = 0, WrData = 0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;
  int total = 0, bad = 0;
  logic [31:0] mhi = 0, mlo = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ph, pl, eh, el;
  } vec_t;
  vec_t tv[8];

  always #5 Clk = ~Clk;

  booth_muldiv_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .MultA(MultA), .MultB(MultB),
    .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    HiWe = 1; WrData = h; tick();
    HiWe = 0; LoWe = 1; WrData = l; tick();
    LoWe = 0;
    mhi = h; mlo = l;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; MultA = a; MultB = b; Start = 1;
    tick();
    Start = 0; MultA = $urandom; MultB = $urandom; Op = 2'($urandom);
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!Done && n < 100) begin
      bc += int'(Busy);
      tick();
      n++;
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    logic signed [63:0] sa, sb;
    logic [63:0] prod;
    sa = $signed(a);
    sb = $signed(b);
    prod = op[0] ? {32'b0, a} * {32'b0, b} : 64'(sa * sb);
    return prod + (op[1] ? acc : 64'd0);
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners[5];
    int r;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    r = $urandom_range(0, 7);
    return r < 5 ? corners[r] : 32'($urandom);
  endfunction

  initial begin
    int n, bc, dc;
    logic [1:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    tv[0] = '{2'd0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tv[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h1};
    tv[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h1};
    tv[3] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 32'h0};
    tv[4] = '{2'd2, 32'd2, 32'd3, 32'h0, 32'd5, 32'h0, 32'd11};
    tv[5] = '{2'd2, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0};
    tv[6] = '{2'd3, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'h2, 32'h3, 32'h0};
    tv[7] = '{2'd2, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    #12;
    check("reset_hi", Hi, 0);
    check("reset_lo", Lo, 0);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    @(posedge Clk); #1 Reset = 0;

    for (int i = 0; i < 8; i++) begin
      preload(tv[i].ph, tv[i].pl);
      start_op(tv[i].op, tv[i].a, tv[i].b);
      wait_done(n, bc);
      check($sformatf("vec%0d_latency", i), n, 34);
      check($sformatf("vec%0d_busy_cycles", i), bc, 34);
      check($sformatf("vec%0d_hi", i), Hi, tv[i].eh);
      check($sformatf("vec%0d_lo", i), Lo, tv[i].el);
      tick();
      check($sformatf("vec%0d_done_pulse", i), Done, 0);
      mhi = tv[i].eh; mlo = tv[i].el;
    end

    // mtlo during RUN is visible but does not disturb the accumulator latched at Start
    preload(32'h0, 32'hFFFF_FFFF);
    start_op(2'd2, 32'd1, 32'd1);
    repeat (3) tick();
    LoWe = 1; WrData = 32'h1234; tick(); LoWe = 0;
    check("lowe_run_visible", Lo, 32'h1234);
    wait_done(n, bc);
    check("lowe_run_done_seen", n < 100, 1);
    check("lowe_run_hi", Hi, 1);
    check("lowe_run_lo", Lo, 0);
    mhi = 1; mlo = 0;

    // second Start during RUN must be ignored and not queued
    start_op(2'd0, 32'd6, 32'd7);
    repeat (4) tick();
    Start = 1; Op = 0; MultA = 100; MultB = 100; tick(); Start = 0;
    dc = 0;
    repeat (40) begin dc += int'(Done); tick(); end
    check("restart_done_count", dc, 1);
    check("restart_hi", Hi, 0);
    check("restart_lo", Lo, 42);
    check("restart_not_busy", Busy, 0);
    mhi = 0; mlo = 42;

    // mthi coinciding with WRITE is dropped
    start_op(2'd0, 32'd5, 32'd5);
    repeat (33) tick();
    HiWe = 1; WrData = 32'hDEAD; tick(); HiWe = 0;
    check("coincide_done", Done, 1);
    check("coincide_hi", Hi, 0);
    check("coincide_lo", Lo, 25);
    tick();
    check("coincide_hi_after", Hi, 0);
    mhi = 0; mlo = 25;

    // asynchronous reset mid-RUN aborts without a result
    preload(32'hAAAA, 32'h5555);
    start_op(2'd0, 32'd3, 32'd3);
    repeat (10) tick();
    Reset = 1;
    #1;
    check("abort_hi", Hi, 0);
    check("abort_lo", Lo, 0);
    check("abort_busy", Busy, 0);
    #1 Reset = 0;
    dc = 0;
    repeat (40) begin dc += int'(Done); tick(); end
    check("abort_no_done", dc, 0);
    check("abort_lo_stays", Lo, 0);
    start_op(2'd0, 32'd4, 32'd5);
    wait_done(n, bc);
    check("after_abort_latency", n, 34);
    check("after_abort_hi", Hi, 0);
    check("after_abort_lo", Lo, 20);
    mhi = 0; mlo = 20;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) preload($urandom, $urandom);
      op = 2'($urandom);
      a = pick();
      b = pick();
      exp = model(op, a, b, {mhi, mlo});
      start_op(op, a, b);
      wait_done(n, bc);
      check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), {Hi, Lo}, exp);
      {mhi, mlo} = exp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
